systolic_input_skew: RTL and testbench

Upstream feeder for a column of the systolic MAC array. It accepts one activation vector of num_rows elements per cycle over a valid/ready handshake. It delays lane r by r extra cycles so the west-edge `data_in` of each PE row receives the wavefront diagonally. After the last vector of a burst, a FLUSH phase drains the skew pipeline and then signals completion.

---
 rtl/systolic_input_skew.sv | 147 ++++++++++++++
 tb/tb_systolic_input_skew.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_input_skew.sv
// Diagonal input skew for one column of the systolic MAC array: lane r of each
// accepted vector reaches PE row r after r extra cycles. Define SKEW_VEC_COUNT_EN for vec_count.
module systolic_input_skew #(
    parameter int unsigned bit_width = 8,
    parameter int unsigned num_rows  = 4
`ifdef SKEW_VEC_COUNT_EN
    ,
    parameter int unsigned cnt_width = 16
`endif
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_last,
    input  logic [num_rows*bit_width-1:0] in_vec,
    output logic [num_rows*bit_width-1:0] skew_data,
    output logic [num_rows-1:0]           skew_valid,
    output logic                          busy,
    output logic                          done
`ifdef SKEW_VEC_COUNT_EN
    ,
    output logic [cnt_width-1:0]          vec_count
`endif
);

    localparam int unsigned FCW = (num_rows > 1) ? $clog2(num_rows) : 1;
    localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(num_rows - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH
    } state_t;

    state_t         state_q, state_d;
    logic [FCW-1:0] flush_cnt_q, flush_cnt_d;
    logic           done_q, done_d;
    logic           accept;

    assign in_ready = (state_q != FLUSH);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE, STREAM: begin
                if (accept) begin
                    if (in_last) begin
                        state_d     = FLUSH;
                        flush_cnt_d = FLUSH_LOAD;
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
            FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // done is registered, so it is raised on entry to the counter==0 FLUSH cycle
        done_d = (state_d == FLUSH) && (flush_cnt_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            done_q      <= done_d;
        end
    end

    for (genvar r = 0; r < num_rows; r++) begin : g_lane
        localparam int unsigned DEPTH = r + 1;

        logic [DEPTH*bit_width-1:0] data_q, data_d;
        logic [DEPTH-1:0]           valid_q, valid_d;
        logic [bit_width-1:0]       head_data;

        // bubbles carry zero data so they contribute nothing to the PE accumulators
        assign head_data = accept ? in_vec[r*bit_width +: bit_width] : '0;

        if (r == 0) begin : g_head
            always_comb begin
                data_d  = head_data;
                valid_d = accept;
            end
        end else begin : g_shift
            always_comb begin
                data_d  = {data_q[r*bit_width-1:0], head_data};
                valid_d = {valid_q[r-1:0], accept};
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                data_q  <= '0;
                valid_q <= '0;
            end else begin
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end

        assign skew_data[r*bit_width +: bit_width] = data_q[r*bit_width +: bit_width];
        assign skew_valid[r]                       = valid_q[r];
    end

`ifdef SKEW_VEC_COUNT_EN
    logic [cnt_width-1:0] vec_count_q, vec_count_d;

    always_comb begin
        vec_count_d = vec_count_q;
        if (accept) begin
            if (state_q == IDLE) begin
                vec_count_d = cnt_width'(1);
            end else if (vec_count_q != '1) begin
                vec_count_d = vec_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vec_count_q <= '0;
        end else begin
            vec_count_q <= vec_count_d;
        end
    end

    assign vec_count = vec_count_q;
`endif

endmodule

// File: tb/tb_systolic_input_skew.sv
// Directed bench for systolic_input_skew (num_rows=4, bit_width=8): reset, single
// vector, streaming, bubbles, backpressure in FLUSH and reset during FLUSH.
module tb_systolic_input_skew;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [31:0] in_vec;
    logic [31:0] skew_data;
    logic [3:0]  skew_valid;
    logic        busy;
    logic        done;
`ifdef SKEW_VEC_COUNT_EN
    logic [15:0] vec_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    systolic_input_skew #(
        .bit_width(8),
        .num_rows (4)
`ifdef SKEW_VEC_COUNT_EN
        ,
        .cnt_width(16)
`endif
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_vec    (in_vec),
        .skew_data (skew_data),
        .skew_valid(skew_valid),
        .busy      (busy),
        .done      (done)
`ifdef SKEW_VEC_COUNT_EN
        ,
        .vec_count (vec_count)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] v, input logic last);
        in_valid = 1'b1;
        in_vec   = v;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_vec   = '0;
    endtask

    // expected outputs after edge k (index k-1)
    logic [3:0]  t2_valid [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [31:0] t2_data  [4] = '{32'h00000001, 32'h00000200, 32'h00030000, 32'h04000000};
    logic [31:0] t3_vec   [3] = '{32'h11111111, 32'h22222222, 32'h33333333};
    logic [3:0]  t3_valid [7] = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    logic [31:0] t3_data  [7] = '{32'h00000011, 32'h00001122, 32'h00112233, 32'h11223300,
                                  32'h22330000, 32'h33000000, 32'h00000000};
    logic [3:0]  t4_valid [6] = '{4'b0001, 4'b0010, 4'b0101, 4'b1010, 4'b0100, 4'b1000};
    logic [31:0] t4_data  [6] = '{32'h000000AA, 32'h0000AA00, 32'h00AA00BB, 32'hAA00BB00,
                                  32'h00BB0000, 32'hBB000000};

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_vec   = '0;
        tick();
        tick();
        reset = 1'b0;

        // 1: asynchronous reset mid-STREAM, checked before any clock edge
        send(32'hDEADBEEF, 1'b0);
        check("t1 busy pre-reset", busy, 1);
        check("t1 valid pre-reset", skew_valid, 4'b0001);
        #2;
        reset = 1'b1;
        #1;
        check("t1 valid", skew_valid, 4'b0000);
        check("t1 data", skew_data, 32'h0);
        check("t1 busy", busy, 0);
        check("t1 done", done, 0);
        tick();
        reset = 1'b0;

        // 2: single-vector burst
        check("t2 ready idle", in_ready, 1);
        send(32'h04030201, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) tick();
            if (k <= 4) begin
                check($sformatf("t2 valid k%0d", k), skew_valid, t2_valid[k-1]);
                check($sformatf("t2 data k%0d", k), skew_data, t2_data[k-1]);
                check($sformatf("t2 ready k%0d", k), in_ready, 0);
                check($sformatf("t2 done k%0d", k), done, (k == 4));
            end else begin
                check("t2 valid idle", skew_valid, 4'b0000);
                check("t2 done idle", done, 0);
                check("t2 busy idle", busy, 0);
                check("t2 ready idle2", in_ready, 1);
            end
        end

        // 3: streaming burst of three vectors, full diagonal check
        for (int k = 1; k <= 7; k++) begin
            if (k <= 3) begin
                in_valid = 1'b1;
                in_vec   = t3_vec[k-1];
                in_last  = (k == 3);
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                in_vec   = '0;
            end
            tick();
            check($sformatf("t3 valid k%0d", k), skew_valid, t3_valid[k-1]);
            check($sformatf("t3 data k%0d", k), skew_data, t3_data[k-1]);
            check($sformatf("t3 done k%0d", k), done, (k == 6));
            check($sformatf("t3 busy k%0d", k), busy, (k <= 6));
        end
`ifdef SKEW_VEC_COUNT_EN
        check("t3 vec_count", vec_count, 3);
`endif

        // 4: bubble between two vectors
        for (int k = 1; k <= 6; k++) begin
            in_valid = (k == 1) || (k == 3);
            in_vec   = (k == 1) ? 32'hAAAAAAAA : (k == 3) ? 32'hBBBBBBBB : 32'h0;
            in_last  = (k == 3);
            tick();
            if (k == 1) check("t4 ready bubble", in_ready, 1);
            check($sformatf("t4 valid k%0d", k), skew_valid, t4_valid[k-1]);
            check($sformatf("t4 data k%0d", k), skew_data, t4_data[k-1]);
            check($sformatf("t4 done k%0d", k), done, (k == 6));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_vec   = '0;
        tick();
        check("t4 busy end", busy, 0);

        // 5: vector held during FLUSH is only accepted once back in IDLE
        send(32'h01020304, 1'b1);
        check("t5 ready k1", in_ready, 0);
        in_valid = 1'b1;
        in_vec   = 32'h55667788;
        in_last  = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            tick();
            check($sformatf("t5 lane0 valid k%0d", k), skew_valid[0], 0);
            check($sformatf("t5 ready k%0d", k), in_ready, (k == 5));
            check($sformatf("t5 done k%0d", k), done, (k == 4));
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_vec   = '0;
        check("t5 accept valid", skew_valid, 4'b0001);
        check("t5 accept data", skew_data, 32'h00000088);
        check("t5 accept busy", busy, 1);
        tick();
        tick();
        tick();
        check("t5 end valid", skew_valid, 4'b1000);
        check("t5 end data", skew_data, 32'h55000000);
        check("t5 end done", done, 1);
        tick();

        // 6: reset while FLUSH counter is 1
        send(32'h0A0B0C0D, 1'b1);
        tick();
        tick();
        check("t6 busy pre-reset", busy, 1);
        check("t6 valid pre-reset", skew_valid, 4'b0100);
        #2;
        reset = 1'b1;
        #1;
        check("t6 valid", skew_valid, 4'b0000);
        check("t6 data", skew_data, 32'h0);
        check("t6 busy", busy, 0);
        check("t6 done", done, 0);
        check("t6 ready", in_ready, 1);
`ifdef SKEW_VEC_COUNT_EN
        check("t6 vec_count reset", vec_count, 0);
`endif
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("t6 no done k%0d", k), done, 0);
            check($sformatf("t6 quiet k%0d", k), skew_valid, 4'b0000);
        end

        // five-vector burst after the reset
        for (int k = 1; k <= 5; k++) begin
            send(32'h01010101 * k, (k == 5));
`ifdef SKEW_VEC_COUNT_EN
            check($sformatf("t6 vec_count k%0d", k), vec_count, k);
`endif
        end
        tick();
        tick();
        tick();
        check("t6 burst done", done, 1);
        check("t6 burst data", skew_data, 32'h05000000);
        tick();
        check("t6 burst idle", busy, 0);
`ifdef SKEW_VEC_COUNT_EN
        check("t6 vec_count held", vec_count, 5);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
